microc_uc: RTL and testbench
============================

Name: microc_uc

Overview:
- Control unit for the single-cycle `microc` datapath. It consumes `Opcode[5:0]` and the zero flag `z`, and produces `s_inc`, `s_inm`, `we`, `wez`, `Op` and a PC enable within the same cycle.
- A small FSM adds three behaviours on top of the decoder:
  - a boot cycle after reset;
  - a halt instruction;
  - a sticky trap on illegal opcodes.
- Optional performance counters are compiled in by macro.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Opcode  input  6  opcode of the current instruction, from datapath
- z  input  1  registered zero flag, from datapath
- s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump target
- s_inm  output  1  register-file write-data select: 1 = immediate, 0 = ALU
- we  output  1  register-file write enable
- wez  output  1  zero-flag write enable
- Op  output  3  ALU operation code
- pc_en  output  1  PC register load enable
- halted  output  1  high in HALT state
- trap  output  1  high in TRAP state
- instr_count  output  CNT_W  instructions executed
- taken_count  output  CNT_W  taken jumps

Behaviour:
- Reset is synchronous and active-high. `clk` is the only clock. On a rising edge with `reset=1`: state <= BOOT, and both counters <= 0.
- States: BOOT, RUN, HALT, TRAP. Encoding is one-hot (4 bits), defined in the package.
- BOOT:
  - All outputs are 0, including `pc_en=0`.
  - Always goes to RUN on the next edge.
  - The instruction at PC 0 executes in the first RUN cycle.
- RUN:
  - Outputs are a combinational (Mealy) decode of `Opcode`/`z`; `pc_en=1`.
  - `ALUR` 00_0ooo: we=1, wez=1, s_inm=0, s_inc=1, Op=ooo.
  - `ALUI` 00_1ooo: we=1, wez=1, s_inm=1, s_inc=1, Op=ooo.
  - `LI` 01_0000: we=1, wez=0, s_inm=1, s_inc=1, Op=000.
  - `J` 10_0000: s_inc=0; we, wez, s_inm = 0; Op=000.
  - `JZ` 10_0001: s_inc=~z; other enables 0.
  - `JNZ` 10_0010: s_inc=z; other enables 0.
  - `NOP` 11_1111: s_inc=1; other enables 0.
  - `HALT` 11_1110: all enables 0, `pc_en=0`; next state HALT.
  - Any other opcode is illegal: all enables 0, `pc_en=0`; next state TRAP.
- ALU codes: 000 = pass A, 010 = ADD, 011 = SUB, 100 = AND. The unit passes `ooo` through unchecked.
- HALT:
  - All enables 0, `pc_en=0`, `halted=1`.
  - Left only by reset.
- TRAP:
  - All enables 0, `pc_en=0`, `trap=1`.
  - Sticky; left only by reset.
- Latency:
  - Control outputs depend on the current cycle's Opcode/z with zero latency.
  - State and counters update on the next edge.
- `z` is sampled as-is; it reflects the flag written by the previous instruction.
- Reset asserted in any state, including HALT or TRAP, wins on that edge.
- `halted` and `trap` are never both 1.

Optional Feature:
- Macro MICROC_PERF_COUNTERS_EN.
- When defined:
  - `instr_count` increments on every edge in RUN where the opcode is legal and not HALT.
  - `taken_count` increments when J executes, JZ executes with z=1, or JNZ executes with z=0.
  - Both saturate at 2^CNT_W-1.
- When undefined: both outputs are constant 0 and no counter flops are inferred.

Decomposition:
- Package `microc_pkg` holds:
  - opcode constants (`OPC_J`, `OPC_JZ`, `OPC_JNZ`, `OPC_LI`, `OPC_NOP`, `OPC_HALT`, and the class prefixes for ALUR/ALUI);
  - ALU op constants (`ALU_PASS`, `ALU_ADD`, `ALU_SUB`, `ALU_AND`);
  - state encoding.
- One sub-module, `microc_uc_decode`: purely combinational opcode/z to control-word decode, plus `illegal` and `is_halt` flags.
- The top level holds the FSM, output gating and counters.

Test Plan:
- Reset high for 2 edges, then release. Expect 1 cycle with all outputs 0 and `pc_en=0`. Then `Opcode=01_0000` gives we=1, s_inm=1, s_inc=1, wez=0.
- RUN, `Opcode=00_0011`: we=1, wez=1, s_inm=0, s_inc=1, Op=011. `Opcode=00_1010`: s_inm=1, Op=010.
- `JNZ` with z=0 gives s_inc=0 and `taken_count` +1. `JNZ` with z=1 gives s_inc=1 and `taken_count` unchanged. `JZ` must give the opposite result in both cases.
- `Opcode=11_1110`: `pc_en=0` that cycle and `halted=1` from the next cycle. Any later opcode (e.g. 00_0010) still gives all enables 0. Reset returns to BOOT.
- `Opcode=01_0101` (illegal): trap=1 from the next cycle and stays 1 for 10 cycles of mixed opcodes. `instr_count` is frozen.
- With the macro and CNT_W=4: 20 `NOP`s give `instr_count=15` (saturated). Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/microc_pkg.sv
// ============================================================================
// Module      : microc_pkg
// Description : Shared opcodes, ALU codes, control word and FSM state encoding
//               for the microc control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package microc_pkg;

   localparam logic [5:0] OPC_J    = 6'b10_0000;
   localparam logic [5:0] OPC_JZ   = 6'b10_0001;
   localparam logic [5:0] OPC_JNZ  = 6'b10_0010;
   localparam logic [5:0] OPC_LI   = 6'b01_0000;
   localparam logic [5:0] OPC_NOP  = 6'b11_1111;
   localparam logic [5:0] OPC_HALT = 6'b11_1110;

   // Opcode[5:3] class prefixes; Opcode[2:0] carries the ALU operation
   localparam logic [2:0] OPC_CLASS_ALUR = 3'b000;
   localparam logic [2:0] OPC_CLASS_ALUI = 3'b001;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;

   typedef enum logic [3:0] {
      ST_BOOT = 4'b0001,
      ST_RUN  = 4'b0010,
      ST_HALT = 4'b0100,
      ST_TRAP = 4'b1000
   } uc_state_t;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we;
      logic       wez;
      logic [2:0] op;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/microc_uc_decode.sv
// ============================================================================
// Module      : microc_uc_decode
// Description : Combinational opcode/z to control-word decoder with illegal
//               and halt flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microc_uc_decode
   import microc_pkg::*;
(
   input  logic [5:0] Opcode,
   input  logic       z,
   output ctrl_t      ctrl,
   output logic       illegal,
   output logic       is_halt
);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      is_halt = 1'b0;
      if (Opcode[5:3] == OPC_CLASS_ALUR) begin
         ctrl.we    = 1'b1;
         ctrl.wez   = 1'b1;
         ctrl.s_inc = 1'b1;
         ctrl.op    = Opcode[2:0];
      end else if (Opcode[5:3] == OPC_CLASS_ALUI) begin
         ctrl.we    = 1'b1;
         ctrl.wez   = 1'b1;
         ctrl.s_inm = 1'b1;
         ctrl.s_inc = 1'b1;
         ctrl.op    = Opcode[2:0];
      end else begin
         case (Opcode)
            OPC_LI: begin
               ctrl.we    = 1'b1;
               ctrl.s_inm = 1'b1;
               ctrl.s_inc = 1'b1;
               ctrl.op    = ALU_PASS;
            end
            OPC_J:    ctrl.s_inc = 1'b0;
            OPC_JZ:   ctrl.s_inc = ~z;
            OPC_JNZ:  ctrl.s_inc = z;
            OPC_NOP:  ctrl.s_inc = 1'b1;
            OPC_HALT: is_halt    = 1'b1;
            default:  illegal    = 1'b1;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/microc_uc.sv
// ============================================================================
// Module      : microc_uc
// Description : microc control unit: decoder plus BOOT/RUN/HALT/TRAP FSM.
//               Define MICROC_PERF_COUNTERS_EN to build the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microc_uc
   import microc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             pc_en,
   output logic             halted,
   output logic             trap,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] taken_count
);

   uc_state_t state;
   ctrl_t     dec_ctrl;
   logic      dec_illegal;
   logic      dec_halt;

   microc_uc_decode u_decode (
      .Opcode  (Opcode),
      .z       (z),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal),
      .is_halt (dec_halt)
   );

   // Only RUN lets the decoded word through; HALT/illegal decode to all-zero
   always_comb begin
      s_inc = 1'b0;
      s_inm = 1'b0;
      we    = 1'b0;
      wez   = 1'b0;
      Op    = ALU_PASS;
      pc_en = 1'b0;
      if (state == ST_RUN) begin
         s_inc = dec_ctrl.s_inc;
         s_inm = dec_ctrl.s_inm;
         we    = dec_ctrl.we;
         wez   = dec_ctrl.wez;
         Op    = dec_ctrl.op;
         pc_en = ~(dec_illegal | dec_halt);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_BOOT;
         halted <= 1'b0;
         trap   <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: state <= ST_RUN;
            ST_RUN: begin
               if (dec_illegal) begin
                  state <= ST_TRAP;
                  trap  <= 1'b1;
               end else if (dec_halt) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
               end
            end
            ST_HALT: state <= ST_HALT;
            ST_TRAP: state <= ST_TRAP;
            default: begin
               state  <= ST_BOOT;
               halted <= 1'b0;
               trap   <= 1'b0;
            end
         endcase
      end
   end

`ifdef MICROC_PERF_COUNTERS_EN
   logic exec;
   logic taken;

   // A legal jump is the only executing instruction that clears s_inc
   assign exec  = (state == ST_RUN) & ~(dec_illegal | dec_halt);
   assign taken = exec & ~dec_ctrl.s_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_count <= '0;
         taken_count <= '0;
      end else begin
         if (exec && (instr_count != {CNT_W{1'b1}}))
            instr_count <= instr_count + 1'b1;
         if (taken && (taken_count != {CNT_W{1'b1}}))
            taken_count <= taken_count + 1'b1;
      end
   end
`else
   assign instr_count = '0;
   assign taken_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_microc_uc.sv
// ============================================================================
// Module      : tb_microc_uc
// Description : Directed, table-driven self-checking bench for microc_uc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microc_uc;

   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [5:0]       Opcode;
   logic             z;
   logic             s_inc, s_inm, we, wez, pc_en, halted, trap;
   logic [2:0]       Op;
   logic [CNT_W-1:0] instr_count, taken_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_instr = 0;
   int exp_taken = 0;

   microc_uc #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .Opcode      (Opcode),
      .z           (z),
      .s_inc       (s_inc),
      .s_inm       (s_inm),
      .we          (we),
      .wez         (wez),
      .Op          (Op),
      .pc_en       (pc_en),
      .halted      (halted),
      .trap        (trap),
      .instr_count (instr_count),
      .taken_count (taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] opc;
      logic       zz;
      logic [7:0] exp_word;   // {s_inc, s_inm, we, wez, Op[2:0], pc_en}
   } vec_t;

   vec_t vecs [12];

   function automatic int sat_cnt(input int n);
`ifdef MICROC_PERF_COUNTERS_EN
      return (n > 15) ? 15 : n;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_word(input string name, input logic [7:0] exp);
      #1;
      check(name, {24'd0, s_inc, s_inm, we, wez, Op, pc_en}, {24'd0, exp});
   endtask

   task automatic check_counts(input string name);
      check({name, "_instr"}, {28'd0, instr_count}, sat_cnt(exp_instr));
      check({name, "_taken"}, {28'd0, taken_count}, sat_cnt(exp_taken));
   endtask

   task automatic check_flags(input string name, input logic h, input logic t);
      check(name, {30'd0, halted, trap}, {30'd0, h, t});
   endtask

   initial begin
      vecs[0]  = '{6'b00_0011, 1'b0, 8'b1011_0111};
      vecs[1]  = '{6'b00_1010, 1'b0, 8'b1111_0101};
      vecs[2]  = '{6'b00_0100, 1'b1, 8'b1011_1001};
      vecs[3]  = '{6'b00_1000, 1'b1, 8'b1111_0001};
      vecs[4]  = '{6'b01_0000, 1'b0, 8'b1110_0001};
      vecs[5]  = '{6'b10_0000, 1'b0, 8'b0000_0001};
      vecs[6]  = '{6'b10_0010, 1'b0, 8'b0000_0001};
      vecs[7]  = '{6'b10_0010, 1'b1, 8'b1000_0001};
      vecs[8]  = '{6'b10_0001, 1'b0, 8'b1000_0001};
      vecs[9]  = '{6'b10_0001, 1'b1, 8'b0000_0001};
      vecs[10] = '{6'b11_1111, 1'b0, 8'b1000_0001};
      vecs[11] = '{6'b00_0111, 1'b1, 8'b1011_1111};

      // Reset for two edges, then one BOOT cycle with everything gated off
      reset  = 1'b1;
      Opcode = 6'b11_1111;
      z      = 1'b0;
      tick();
      tick();
      check_word("reset_ctrl", 8'h00);
      check_flags("reset_flags", 1'b0, 1'b0);
      check_counts("reset");
      reset  = 1'b0;
      Opcode = 6'b01_0000;
      check_word("boot_ctrl", 8'h00);
      tick();
      check_word("first_li", 8'b1110_0001);
      tick();
      exp_instr++;
      check_counts("first_li");

      foreach (vecs[i]) begin
         Opcode = vecs[i].opc;
         z      = vecs[i].zz;
         check_word($sformatf("vec%0d_ctrl", i), vecs[i].exp_word);
         tick();
         exp_instr++;
         if (vecs[i].exp_word[7] == 1'b0) exp_taken++;
         check_counts($sformatf("vec%0d", i));
      end

      // HALT: PC frozen this cycle, halted from the next, cleared by reset
      Opcode = 6'b11_1110;
      z      = 1'b0;
      check_word("halt_ctrl", 8'h00);
      check_flags("halt_pre", 1'b0, 1'b0);
      tick();
      check_flags("halt_post", 1'b1, 1'b0);
      Opcode = 6'b00_0010;
      for (int k = 0; k < 3; k++) begin
         check_word($sformatf("halt_hold%0d", k), 8'h00);
         check_flags($sformatf("halt_flag%0d", k), 1'b1, 1'b0);
         tick();
      end
      check_counts("halt");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_instr = 0;
      exp_taken = 0;
      check_flags("halt_reset", 1'b0, 1'b0);
      check_word("halt_boot", 8'h00);
      check_counts("halt_reset");
      tick();

      // Illegal opcode: sticky trap, counters frozen
      Opcode = 6'b11_1111;
      check_word("pre_trap_nop", 8'b1000_0001);
      Opcode = 6'b01_0101;
      check_word("illegal_ctrl", 8'h00);
      tick();
      check_flags("trap_set", 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         case (k % 4)
            0: Opcode = 6'b00_0011;
            1: Opcode = 6'b10_0000;
            2: Opcode = 6'b11_1110;
            default: Opcode = 6'b11_1111;
         endcase
         z = k[0];
         check_word($sformatf("trap_ctrl%0d", k), 8'h00);
         check_flags($sformatf("trap_flag%0d", k), 1'b0, 1'b1);
         tick();
      end
      check_counts("trap");

      // Counter saturation
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      Opcode = 6'b11_1111;
      check_flags("trap_reset", 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 20; k++) tick();
      exp_instr = 20;
      check_counts("sat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
